wb_posted_write_buf: RTL and testbench

- Posted-write buffer and bus adapter between the PicoRV DMA Wishbone master port and the system crossbar.
- Absorbs DMA writes into a FIFO, acks them immediately and drains them onto a pipelined WB master port, honouring stall and err.
- Reads are strongly ordered behind all buffered writes.
- Captures write errors, which the DMA master port cannot observe, in a sticky status with the faulting address.

---
 rtl/wb_pwb_pkg.sv | 14 +
 rtl/wb_pwb_fifo.sv | 49 ++++
 rtl/wb_posted_write_buf.sv | 172 +++++++++++++++++
 tb/tb_wb_posted_write_buf.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pwb_pkg.sv
// Shared types for the posted-write buffer: FIFO entry layout and master FSM states.
package wb_pwb_pkg;
    localparam int PWB_ADR_W = 30;

    typedef struct packed {
        logic [PWB_ADR_W-1:0] adr;
        logic [31:0]          dat;
        logic [3:0]           sel;
    } wb_pwb_entry_t;

    localparam int PWB_ENTRY_W = $bits(wb_pwb_entry_t);

    typedef enum logic [1:0] {IDLE, WR, RD, WAIT} wb_pwb_state_t;
endpackage

// File: rtl/wb_pwb_fifo.sv
// First-word-fall-through FIFO of posted write entries; storage is not reset.
module wb_pwb_fifo
    import wb_pwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [PWB_ENTRY_W-1:0] din,
    output logic [PWB_ENTRY_W-1:0] head,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PWB_ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;
    logic                   do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_posted_write_buf.sv
// Posted-write buffer between the DMA WB master and the crossbar: writes are acked
// at once and drained in order; reads wait behind them; write errors are latched.
module wb_posted_write_buf
    import wb_pwb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADR_W = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] s_adr,
    input  logic [31:0]      s_dat_w,
    input  logic [3:0]       s_sel,
    input  logic             s_we,
    input  logic             s_stb,
    input  logic             s_cyc,
    output logic [31:0]      s_dat_r,
    output logic             s_ack,
    output logic             s_stall,
    output logic             s_err,
    output logic [ADR_W-1:0] m_adr,
    output logic [31:0]      m_dat_w,
    output logic [3:0]       m_sel,
    output logic             m_we,
    output logic             m_stb,
    output logic             m_cyc,
    input  logic [31:0]      m_dat_r,
    input  logic             m_ack,
    input  logic             m_stall,
    input  logic             m_err,
    output logic             err_flag,
    output logic [ADR_W-1:0] err_adr,
    input  logic             err_clr,
    output logic             busy
);
    wb_pwb_state_t    state, state_nxt;
    wb_pwb_entry_t    push_ent, head;
    logic             fifo_full, fifo_empty, pop;
    logic             slv_req, wr_acc, rd_acc, done;
    logic             rd_pend, rd_drop;
    logic [ADR_W-1:0] m_adr_nxt;
    logic [31:0]      m_dat_w_nxt;
    logic [3:0]       m_sel_nxt;
    logic             m_we_nxt, m_stb_nxt, m_cyc_nxt;

    assign slv_req  = s_cyc & s_stb;
    assign wr_acc   = slv_req & s_we & ~fifo_full & ~rd_pend;
    assign rd_acc   = slv_req & ~s_we & fifo_empty & (state == IDLE) & ~rd_pend;
    assign s_stall  = rd_pend | (slv_req & (s_we ? fifo_full : ~(fifo_empty & (state == IDLE))));
    assign pop      = (state == WR) & ~m_stall;
    assign done     = (state == WAIT) & (m_ack | m_err);
    assign busy     = ~fifo_empty | (state != IDLE);
    assign push_ent = '{adr: PWB_ADR_W'(s_adr), dat: s_dat_w, sel: s_sel};

    wb_pwb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_acc),
        .pop   (pop),
        .din   (push_ent),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt   = state;
        m_adr_nxt   = m_adr;
        m_dat_w_nxt = m_dat_w;
        m_sel_nxt   = m_sel;
        m_we_nxt    = m_we;
        m_stb_nxt   = m_stb;
        m_cyc_nxt   = m_cyc;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt   = WR;
                    m_adr_nxt   = head.adr[ADR_W-1:0];
                    m_dat_w_nxt = head.dat;
                    m_sel_nxt   = head.sel;
                    m_we_nxt    = 1'b1;
                    m_stb_nxt   = 1'b1;
                    m_cyc_nxt   = 1'b1;
                end else if (rd_acc) begin
                    state_nxt   = RD;
                    m_adr_nxt   = s_adr;
                    m_dat_w_nxt = '0;
                    m_sel_nxt   = 4'hF;
                    m_we_nxt    = 1'b0;
                    m_stb_nxt   = 1'b1;
                    m_cyc_nxt   = 1'b1;
                end
            end
            WR, RD: begin
                if (!m_stall) begin
                    state_nxt = WAIT;
                    m_stb_nxt = 1'b0;
                end
            end
            WAIT: begin
                // Chain queued writes inside one bus cycle; a read always ends it.
                if (m_ack || m_err) begin
                    if (m_we && !fifo_empty) begin
                        state_nxt   = WR;
                        m_adr_nxt   = head.adr[ADR_W-1:0];
                        m_dat_w_nxt = head.dat;
                        m_sel_nxt   = head.sel;
                        m_stb_nxt   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        m_we_nxt  = 1'b0;
                        m_cyc_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            m_adr    <= '0;
            m_dat_w  <= '0;
            m_sel    <= '0;
            m_we     <= 1'b0;
            m_stb    <= 1'b0;
            m_cyc    <= 1'b0;
            s_ack    <= 1'b0;
            s_err    <= 1'b0;
            s_dat_r  <= '0;
            rd_pend  <= 1'b0;
            rd_drop  <= 1'b0;
            err_flag <= 1'b0;
            err_adr  <= '0;
        end else begin
            state   <= state_nxt;
            m_adr   <= m_adr_nxt;
            m_dat_w <= m_dat_w_nxt;
            m_sel   <= m_sel_nxt;
            m_we    <= m_we_nxt;
            m_stb   <= m_stb_nxt;
            m_cyc   <= m_cyc_nxt;
            s_ack   <= wr_acc;
            s_err   <= 1'b0;

            if (rd_acc) begin
                rd_pend <= 1'b1;
                rd_drop <= 1'b0;
            end else if (rd_pend && !s_cyc) begin
                rd_drop <= 1'b1;
            end

            // An abandoned read still completes on the bus but returns nothing.
            if (done && !m_we) begin
                rd_pend <= 1'b0;
                if (!rd_drop && s_cyc) begin
                    s_ack   <= ~m_err;
                    s_err   <= m_err;
                    s_dat_r <= m_dat_r;
                end
            end

            if (done && m_we && m_err) begin
                err_flag <= 1'b1;
                if (!err_flag || err_clr) err_adr <= m_adr;
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_posted_write_buf.sv
// Randomised bench: a pipelined WB memory slave on the master side, a byte-lane
// reference memory and an expected bus-order queue built from slave-side traffic.
module tb_wb_posted_write_buf;
    localparam int DEPTH = 4;
    localparam int ADR_W = 30;

    typedef struct {
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    logic [ADR_W-1:0] s_adr, m_adr, err_adr;
    logic [31:0] s_dat_w, s_dat_r, m_dat_w, m_dat_r;
    logic [3:0]  s_sel, m_sel;
    logic s_we, s_stb, s_cyc, s_ack, s_stall, s_err;
    logic m_we, m_stb, m_cyc, m_ack, m_stall, m_err;
    logic err_flag, err_clr, busy;

    int tests = 0, fails = 0;
    int cyc_n = 0;
    int stall_mode = 0;
    int last_ack_cyc = 0;
    txn_t mlog[$];
    txn_t exp_q[$];
    logic [31:0] slave_mem [int];
    logic [31:0] ref_mem [int];
    bit err_set [int];

    wb_posted_write_buf #(.DEPTH(DEPTH), .ADR_W(ADR_W)) dut (
        .clk(clk), .rst(rst),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_stall(s_stall), .s_err(s_err),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_we(m_we), .m_stb(m_stb), .m_cyc(m_cyc),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_stall(m_stall), .m_err(m_err),
        .err_flag(err_flag), .err_adr(err_adr), .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sl);
        for (int b = 0; b < 4; b++) if (sl[b]) old[b*8 +: 8] = d[b*8 +: 8];
        return old;
    endfunction

    // Master-side stall source: 0 = never, 1 = always, otherwise random.
    initial begin
        m_stall = 1'b0;
        forever begin
            @(negedge clk);
            case (stall_mode)
                0:       m_stall = 1'b0;
                1:       m_stall = 1'b1;
                default: m_stall = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Memory slave: responds one cycle after a request is taken.
    initial begin
        bit   acc_prev;
        int   p_adr;
        logic p_we;
        txn_t t;
        acc_prev = 1'b0; p_adr = 0; p_we = 1'b0;
        m_ack = 1'b0; m_err = 1'b0; m_dat_r = '0;
        forever begin
            @(negedge clk);
            #1;
            m_ack = 1'b0;
            m_err = 1'b0;
            if (acc_prev) begin
                if (err_set.exists(p_adr)) m_err = 1'b1; else m_ack = 1'b1;
                if (!p_we) m_dat_r = slave_mem.exists(p_adr) ? slave_mem[p_adr] : 32'h0;
                last_ack_cyc = cyc_n;
            end
            acc_prev = m_cyc & m_stb & ~m_stall;
            if (acc_prev) begin
                p_adr = int'(m_adr);
                p_we  = m_we;
                t = '{m_we, m_adr, m_dat_w, m_sel};
                mlog.push_back(t);
                if (m_we) slave_mem[p_adr] = merge(slave_mem.exists(p_adr) ? slave_mem[p_adr] : 32'h0, m_dat_w, m_sel);
            end
        end
    end

    task automatic slave_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] sl,
                               output int waited, output bit acked);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = a; s_dat_w = d; s_sel = sl;
        waited = 0;
        #1;
        while (s_stall && waited < 200) begin @(negedge clk); #1; waited++; end
        @(negedge clk);
        acked = s_ack;
        s_stb = 1'b0; s_cyc = 1'b0; s_we = 1'b0;
        if (waited < 200) begin
            ref_mem[int'(a)] = merge(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0, d, sl);
            exp_q.push_back('{1'b1, a, d, sl});
        end
    endtask

    task automatic slave_read(input logic [29:0] a, output int waited, output int lat, output bit acked,
                              output bit erred, output logic [31:0] data, output int ack_cyc);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = a; s_sel = 4'hF;
        waited = 0;
        #1;
        while (s_stall && waited < 200) begin @(negedge clk); #1; waited++; end
        @(negedge clk);
        s_stb = 1'b0;
        lat = 1;
        while (!(s_ack || s_err) && lat < 200) begin @(negedge clk); lat++; end
        acked = s_ack; erred = s_err; data = s_dat_r; ack_cyc = cyc_n;
        s_cyc = 1'b0;
        exp_q.push_back('{1'b0, a, 32'h0, 4'hF});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({m_cyc, m_stb, m_we, s_ack, s_err, s_stall, err_flag, busy} !== 8'h0) begin
            fails++; $display("FAIL reset_ctrl got %b want 00000000", {m_cyc, m_stb, m_we, s_ack, s_err, s_stall, err_flag, busy});
        end
        tests++;
        if (m_adr !== '0 || err_adr !== '0 || s_dat_r !== '0 || m_dat_w !== '0 || m_sel !== '0) begin
            fails++; $display("FAIL reset_data m_adr=%h err_adr=%h s_dat_r=%h m_dat_w=%h m_sel=%h want all 0",
                              m_adr, err_adr, s_dat_r, m_dat_w, m_sel);
        end
    endtask

    task automatic test_single_write();
        stall_mode = 0;
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 30'h100; s_dat_w = 32'hDEADBEEF; s_sel = 4'hF;
        #1;
        tests++; if (s_stall !== 1'b0) begin fails++; $display("FAIL single_stall got %b want 0", s_stall); end
        @(negedge clk);
        tests++; if (s_ack !== 1'b1 || m_stb !== 1'b0) begin fails++; $display("FAIL single_T1 s_ack=%b m_stb=%b want 1 0", s_ack, m_stb); end
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        ref_mem[32'h100] = 32'hDEADBEEF;
        exp_q.push_back('{1'b1, 30'h100, 32'hDEADBEEF, 4'hF});
        @(negedge clk);
        tests++;
        if ({m_cyc, m_stb, m_we} !== 3'b111 || m_adr !== 30'h100 || m_dat_w !== 32'hDEADBEEF || m_sel !== 4'hF) begin
            fails++; $display("FAIL single_T2 cyc/stb/we=%b adr=%h dat=%h sel=%h want 111 100 deadbeef f",
                              {m_cyc, m_stb, m_we}, m_adr, m_dat_w, m_sel);
        end
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_T3 got %b want 1", busy); end
        @(negedge clk);
        tests++; if (busy !== 1'b0 || m_cyc !== 1'b0) begin fails++; $display("FAIL single_idle_T4 busy=%b m_cyc=%b want 0 0", busy, m_cyc); end
    endtask

    task automatic test_back_to_back();
        logic [29:0] a [5];
        logic [31:0] d [5];
        int w, w5, gap, base, n, bad;
        bit ack, ack5;
        stall_mode = 1;
        repeat (2) @(negedge clk);
        base = mlog.size();
        for (int i = 0; i < 5; i++) begin a[i] = 30'h300 + 30'(i); d[i] = $urandom; end
        for (int i = 0; i < 4; i++) begin
            slave_write(a[i], d[i], 4'hF, w, ack);
            tests++; if (w !== 0 || ack !== 1'b1) begin fails++; $display("FAIL b2b_write%0d waited=%0d ack=%b want 0 1", i, w, ack); end
        end
        tests++; if (m_stb !== 1'b1 || m_adr !== a[0]) begin fails++; $display("FAIL b2b_head m_stb=%b m_adr=%h want 1 %h", m_stb, m_adr, a[0]); end
        fork
            slave_write(a[4], d[4], 4'hF, w5, ack5);
            begin repeat (3) @(negedge clk); stall_mode = 0; end
        join
        tests++; if (w5 < 2 || w5 >= 200 || ack5 !== 1'b1) begin fails++; $display("FAIL b2b_full_stall waited=%0d ack=%b want 2..199 1", w5, ack5); end
        gap = 0;
        for (n = 0; n < 200 && busy; n++) begin
            @(negedge clk);
            if (busy && !m_cyc) gap++;
        end
        tests++; if (gap !== 0 || busy !== 1'b0) begin fails++; $display("FAIL b2b_cyc_held gaps=%0d busy=%b want 0 0", gap, busy); end
        bad = 0;
        for (int i = 0; i < 5; i++)
            if (mlog.size() <= base + i || mlog[base+i].adr !== a[i] || mlog[base+i].dat !== d[i] || !mlog[base+i].we) bad++;
        tests++; if (bad !== 0 || mlog.size() !== base + 5) begin fails++; $display("FAIL b2b_order bad=%0d count=%0d want 0 5", bad, mlog.size() - base); end
    endtask

    task automatic test_write_then_read();
        int w, rw, lat, ack_cyc, base;
        bit ack, rack, rerr;
        logic [31:0] d, data;
        stall_mode = 0;
        @(negedge clk);
        base = mlog.size();
        d = $urandom;
        slave_write(30'h200, d, 4'hF, w, ack);
        slave_read(30'h200, rw, lat, rack, rerr, data, ack_cyc);
        tests++; if (rw < 2 || rw >= 200) begin fails++; $display("FAIL wr_rd_stalled waited=%0d want 2..199", rw); end
        tests++; if (rack !== 1'b1 || rerr !== 1'b0 || data !== d) begin fails++; $display("FAIL wr_rd_data ack=%b err=%b data=%h want 1 0 %h", rack, rerr, data, d); end
        tests++; if (ack_cyc - last_ack_cyc !== 1) begin fails++; $display("FAIL wr_rd_ack_delay got %0d want 1", ack_cyc - last_ack_cyc); end
        tests++;
        if (mlog.size() !== base + 2 || !mlog[base].we || mlog[base].adr !== 30'h200 || mlog[base+1].we || mlog[base+1].adr !== 30'h200) begin
            fails++; $display("FAIL wr_rd_order count=%0d want write then read of 200", mlog.size() - base);
        end
        slave_read(30'h200, rw, lat, rack, rerr, data, ack_cyc);
        tests++; if (rw !== 0 || lat !== 3 || data !== d) begin fails++; $display("FAIL rd_latency waited=%0d lat=%0d data=%h want 0 3 %h", rw, lat, data, d); end
    endtask

    task automatic test_write_err();
        int w, n, base;
        bit ack, found;
        stall_mode = 0;
        err_set[32'h11] = 1'b1;
        base = mlog.size();
        slave_write(30'h10, $urandom, 4'hF, w, ack);
        slave_write(30'h11, $urandom, 4'hF, w, ack);
        slave_write(30'h12, $urandom, 4'hF, w, ack);
        for (n = 0; n < 200 && busy; n++) @(negedge clk);
        tests++; if (err_flag !== 1'b1 || err_adr !== 30'h11) begin fails++; $display("FAIL err_first flag=%b adr=%h want 1 11", err_flag, err_adr); end
        tests++; if (mlog.size() !== base + 3 || mlog[base+2].adr !== 30'h12) begin fails++; $display("FAIL err_third_issued count=%0d want 3", mlog.size() - base); end
        err_set[32'h30] = 1'b1;
        slave_write(30'h30, $urandom, 4'hF, w, ack);
        for (n = 0; n < 200 && busy; n++) @(negedge clk);
        tests++; if (err_flag !== 1'b1 || err_adr !== 30'h11) begin fails++; $display("FAIL err_keep_first flag=%b adr=%h want 1 11", err_flag, err_adr); end
        err_set[32'h31] = 1'b1;
        slave_write(30'h31, $urandom, 4'hF, w, ack);
        found = 1'b0;
        for (n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            #2;
            if (m_err) begin found = 1'b1; err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; end
        end
        tests++; if (!found || err_flag !== 1'b1 || err_adr !== 30'h31) begin fails++; $display("FAIL err_clr_collide found=%b flag=%b adr=%h want 1 1 31", found, err_flag, err_adr); end
        for (n = 0; n < 200 && busy; n++) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL err_clr got %b want 0", err_flag); end
    endtask

    task automatic test_read_err();
        int rw, lat, ack_cyc, n;
        bit rack, rerr, seen;
        logic [31:0] data;
        stall_mode = 0;
        err_set[32'h40] = 1'b1;
        @(negedge clk);
        slave_read(30'h40, rw, lat, rack, rerr, data, ack_cyc);
        tests++; if (rerr !== 1'b1 || rack !== 1'b0) begin fails++; $display("FAIL rd_err err=%b ack=%b want 1 0", rerr, rack); end
        stall_mode = 1;
        repeat (2) @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 30'h41; s_sel = 4'hF;
        #1;
        tests++; if (s_stall !== 1'b0) begin fails++; $display("FAIL rd_drop_accept s_stall=%b want 0", s_stall); end
        @(negedge clk);
        s_stb = 1'b0; s_cyc = 1'b0;
        exp_q.push_back('{1'b0, 30'h41, 32'h0, 4'hF});
        repeat (2) @(negedge clk);
        stall_mode = 0;
        seen = 1'b0;
        for (n = 0; n < 20; n++) begin @(negedge clk); if (s_ack || s_err) seen = 1'b1; end
        tests++; if (seen !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rd_drop_no_ack seen=%b busy=%b want 0 0", seen, busy); end
        slave_read(30'h42, rw, lat, rack, rerr, data, ack_cyc);
        tests++; if (rack !== 1'b1 || lat !== 3) begin fails++; $display("FAIL rd_after_drop ack=%b lat=%0d want 1 3", rack, lat); end
    endtask

    task automatic test_random();
        int w, rw, lat, ack_cyc, n, base, bad, nexp;
        bit ack, rerr;
        logic [29:0] a;
        logic [31:0] data, expd;
        stall_mode = 2;
        @(negedge clk);
        base = mlog.size();
        nexp = exp_q.size();
        for (int i = 0; i < 40; i++) begin
            a = 30'h80 + 30'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 7) begin
                slave_write(a, $urandom, 4'($urandom_range(1, 15)), w, ack);
                tests++; if (w >= 200 || ack !== 1'b1) begin fails++; $display("FAIL rand_write%0d waited=%0d ack=%b want <200 1", i, w, ack); end
            end else begin
                expd = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
                slave_read(a, rw, lat, ack, rerr, data, ack_cyc);
                tests++; if (ack !== 1'b1 || data !== expd) begin fails++; $display("FAIL rand_read%0d adr=%h ack=%b data=%h want 1 %h", i, a, ack, data, expd); end
            end
        end
        for (n = 0; n < 400 && busy; n++) @(negedge clk);
        bad = 0;
        for (int i = 0; i < exp_q.size() - nexp; i++) begin
            if (mlog.size() <= base + i) bad++;
            else if (mlog[base+i].we !== exp_q[nexp+i].we || mlog[base+i].adr !== exp_q[nexp+i].adr || mlog[base+i].sel !== exp_q[nexp+i].sel ||
                     (exp_q[nexp+i].we && mlog[base+i].dat !== exp_q[nexp+i].dat)) bad++;
        end
        tests++;
        if (bad !== 0 || mlog.size() - base !== exp_q.size() - nexp || busy !== 1'b0) begin
            fails++; $display("FAIL rand_bus_order bad=%0d got=%0d want=%0d busy=%b", bad, mlog.size() - base, exp_q.size() - nexp, busy);
        end
    endtask

    task automatic test_reset_mid();
        int w, n, base;
        bit ack;
        stall_mode = 0;
        err_set[32'h50] = 1'b1;
        slave_write(30'h50, $urandom, 4'hF, w, ack);
        for (n = 0; n < 200 && busy; n++) @(negedge clk);
        tests++; if (err_flag !== 1'b1) begin fails++; $display("FAIL rst_pre_flag got %b want 1", err_flag); end
        stall_mode = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) slave_write(30'h60 + 30'(i), $urandom, 4'hF, w, ack);
        @(negedge clk);
        tests++; if (m_stb !== 1'b1 || m_adr !== 30'h60) begin fails++; $display("FAIL rst_pre_wr m_stb=%b m_adr=%h want 1 60", m_stb, m_adr); end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (m_cyc !== 1'b0 || m_stb !== 1'b0 || busy !== 1'b0 || err_flag !== 1'b0) begin
            fails++; $display("FAIL rst_mid m_cyc=%b m_stb=%b busy=%b err_flag=%b want 0 0 0 0", m_cyc, m_stb, busy, err_flag);
        end
        rst = 1'b0;
        base = mlog.size();
        stall_mode = 0;
        repeat (10) @(negedge clk);
        tests++; if (mlog.size() !== base || busy !== 1'b0) begin fails++; $display("FAIL rst_discard issued=%0d busy=%b want 0 0", mlog.size() - base, busy); end
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0;
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_adr = '0; s_dat_w = '0; s_sel = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_write_then_read();
        test_write_err();
        test_read_err();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout after %0d cycles", cyc_n);
        $fatal(1, "timeout");
    end
endmodule
